// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read arbiter slice.
// The FSM encoding and the per-burst context live here so the top and the bench agree.
package flash_pkg;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_DATA,
    ST_ACK
  } state_t;

  // Context of the burst currently owned by one requester.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              owner;
  } burst_t;

  // Word-address step; wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is accepted.
// After reset requester 1 counts as last served, so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_one;

  // NOTE: every always_comb output is defaulted first so no latch can be inferred.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_one ? 2'b01 : 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_one <= 1'b1;
    end else if (accept) begin
      last_one <= grant[1];
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates two burst readers onto a single word-at-a-time flash master.
// A post-reset drain window absorbs any word the master still holds from an aborted burst.
module flash_read_arbiter
  import flash_pkg::*;
#(
  parameter int DRAIN_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic              req0_done,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic              req1_done,

  output logic [DATA_W-1:0] rdata,
  output logic              busy,

  input  logic              m_inited,
  output logic              m_addr_en,
  output logic [ADDR_W-1:0] m_addr_data,
  input  logic              m_rd_data_available,
  input  logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_ack
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  drain_cnt;
  logic              drain_ack;
  burst_t            burst;
  logic              busy_r;
  logic [DATA_W-1:0] rdata_r;

  logic [1:0] grant;
  logic       accept;
  logic       last_word;
  logic       drain_take;
  logic       drain_full;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept     = (state == ST_ARB) && (grant != 2'b00);
  assign last_word  = (burst.remaining == '0);
  // A stale word is taken once; the cycle carrying the ack must not re-take it.
  assign drain_take = m_rd_data_available && !drain_ack;
  assign drain_full = (drain_cnt == CNT_W'(DRAIN_CYC));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_DRAIN:     if (!drain_take && drain_full) state_nxt = ST_IDLE;
      ST_IDLE:      if (m_inited && !m_rd_data_available) state_nxt = ST_ARB;
      ST_ARB:       if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: if (m_rd_data_available) state_nxt = ST_ACK;
      ST_ACK:       state_nxt = last_word ? ST_ARB : ST_ISSUE;
      default:      state_nxt = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_DRAIN;
      drain_cnt <= '0;
      drain_ack <= 1'b0;
      burst     <= '0;
      busy_r    <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state     <= state_nxt;
      drain_ack <= 1'b0;

      if (state == ST_DRAIN) begin
        if (drain_take) begin
          drain_ack <= 1'b1;
          drain_cnt <= '0;
        end else if (!drain_full) begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end

      if (accept) begin
        burst.addr      <= grant[1] ? req1_addr : req0_addr;
        burst.remaining <= grant[1] ? req1_len  : req0_len;
        burst.owner     <= grant[1];
        busy_r          <= 1'b1;
      end

      // Captured on detect so rdata is already stable during the ACK cycle.
      if (state == ST_WAIT_DATA && m_rd_data_available) begin
        rdata_r <= m_rd_data;
      end

      if (state == ST_ACK) begin
        if (last_word) begin
          busy_r <= 1'b0;
        end else begin
          burst.addr      <= next_word_addr(burst.addr);
          burst.remaining <= burst.remaining - 1'b1;
        end
      end
    end
  end

  assign req0_ready  = (state == ST_ARB) && grant[0];
  assign req1_ready  = (state == ST_ARB) && grant[1];
  assign req0_rvalid = (state == ST_ACK) && !burst.owner;
  assign req1_rvalid = (state == ST_ACK) &&  burst.owner;
  assign req0_done   = req0_rvalid && last_word;
  assign req1_done   = req1_rvalid && last_word;

  assign m_addr_en   = (state == ST_ISSUE);
  assign m_addr_data = burst.addr;
  assign m_rd_ack    = (state == ST_ACK) || drain_ack;
  assign rdata       = rdata_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a small behavioural flash master model.
// Expected addresses, data, grant order and timing are written out by hand below.
module tb_flash_read_arbiter;
  import flash_pkg::*;

  localparam int DRAIN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_len = '0, req1_len = '0;
  logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_done, req1_done;
  logic [31:0] rdata;
  logic        busy;
  logic        m_inited = 1'b0;
  logic        m_addr_en;
  logic [23:0] m_addr_data;
  logic        m_rd_data_available;
  logic [31:0] m_rd_data;
  logic        m_rd_ack;

  always #5 clk = ~clk;

  flash_read_arbiter #(.DRAIN_CYC(DRAIN)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req0_valid          (req0_valid),
    .req0_addr           (req0_addr),
    .req0_len            (req0_len),
    .req0_ready          (req0_ready),
    .req0_rvalid         (req0_rvalid),
    .req0_done           (req0_done),
    .req1_valid          (req1_valid),
    .req1_addr           (req1_addr),
    .req1_len            (req1_len),
    .req1_ready          (req1_ready),
    .req1_rvalid         (req1_rvalid),
    .req1_done           (req1_done),
    .rdata               (rdata),
    .busy                (busy),
    .m_inited            (m_inited),
    .m_addr_en           (m_addr_en),
    .m_addr_data         (m_addr_data),
    .m_rd_data_available (m_rd_data_available),
    .m_rd_data           (m_rd_data),
    .m_rd_ack            (m_rd_ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [23:0] a);
    return {8'hC3, a};
  endfunction

  // Flash master model: word appears rd_lat cycles after the strobe and is
  // withdrawn once acked (one cycle later when hold_mode is set).
  int rd_lat = 3;
  bit hold_mode = 1'b0;

  initial begin : master_model
    int          cnt;
    bit          pend;
    bit          drop_next;
    logic [23:0] a;
    cnt = 0; pend = 1'b0; drop_next = 1'b0; a = '0;
    m_rd_data_available = 1'b0;
    m_rd_data = '0;
    forever begin
      @(negedge clk);
      if (drop_next) begin
        m_rd_data_available = 1'b0;
        drop_next = 1'b0;
      end else if (m_rd_ack && m_rd_data_available) begin
        if (hold_mode) drop_next = 1'b1;
        else m_rd_data_available = 1'b0;
      end
      if (m_addr_en) begin
        a = m_addr_data; cnt = rd_lat; pend = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          m_rd_data_available = 1'b1;
          m_rd_data = word_of(a);
          pend = 1'b0;
        end
      end
    end
  end

  typedef struct packed {
    logic        who;
    logic [31:0] data;
    logic        done;
  } rv_t;

  logic [23:0] addr_q[$];
  rv_t         rv_q[$];
  int          grant_q[$];
  int cyc = 0, addr_en_cnt = 0, ack_cnt = 0, drain_ack_cnt = 0, viol = 0;
  int last_drain_ack_cyc = -1, last_addr_en_cyc = -1;

  initial begin : collector
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (m_addr_en) begin
          addr_en_cnt++;
          addr_q.push_back(m_addr_data);
          last_addr_en_cyc = cyc;
        end
        if (m_rd_ack) begin
          ack_cnt++;
          if (!req0_rvalid && !req1_rvalid) begin
            drain_ack_cnt++;
            last_drain_ack_cyc = cyc;
          end
        end
        if (req0_rvalid) rv_q.push_back('{1'b0, rdata, req0_done});
        if (req1_rvalid) rv_q.push_back('{1'b1, rdata, req1_done});
      end
    end
  end

  initial begin : strobe_monitor
    forever begin
      @(posedge clk);
      if (!reset && m_addr_en && m_rd_data_available) viol++;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic run_reqs(input bit use0, input bit use1,
                          input logic [23:0] a0, input logic [7:0] l0,
                          input logic [23:0] a1, input logic [7:0] l1);
    bit pend0, pend1;
    int budget;
    pend0 = use0; pend1 = use1; budget = 0;
    @(negedge clk);
    req0_addr = a0; req0_len = l0; req1_addr = a1; req1_len = l1;
    req0_valid = use0; req1_valid = use1;
    while ((pend0 || pend1) && budget < 5000) begin
      #1;
      if (req0_ready) begin
        grant_q.push_back(0); pend0 = 1'b0;
        @(posedge clk); #1; req0_valid = 1'b0;
      end else if (req1_ready) begin
        grant_q.push_back(1); pend1 = 1'b0;
        @(posedge clk); #1; req1_valid = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    if (pend0 || pend1) begin
      check("grant_timeout", 32'd0, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic wait_rv(input int n);
    int budget;
    budget = 0;
    while (rv_q.size() < n && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (rv_q.size() < n) check("rv_timeout", rv_q.size(), n);
    repeat (2) @(negedge clk);
  endtask

  int          exp_grant[9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic [23:0] exp_addr[13]  = '{24'h001000, 24'h001004, 24'h002000, 24'h002004,
                                 24'h003000, 24'h003004, 24'h004000, 24'h004004,
                                 24'h005000, 24'h007000, 24'h007004, 24'h006000, 24'h006004};
  int          exp_who[13]   = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0};
  int          exp_done[13]  = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
  logic [23:0] exp_wrap[4]   = '{24'hFFFFF8, 24'hFFFFFC, 24'h000000, 24'h000004};

  initial begin : main
    int rv_before, drain_before, ack_before, aen_before, budget;

    // Reset state, with a request already pending to prove ready stays low.
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_m_addr_data", m_addr_data, 0);
    check("rst_m_addr_en", m_addr_en, 0);
    check("rst_m_rd_ack", m_rd_ack, 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    m_inited = 1'b1;

    // Single-word burst from requester 0.
    run_reqs(1, 0, 24'h000100, 8'd0, 24'h0, 8'd0);
    wait_rv(1);
    check("single_strobes", addr_en_cnt, 1);
    check("single_addr", addr_q[0], 24'h000100);
    check("single_who", rv_q[0].who, 0);
    check("single_data", rv_q[0].data, word_of(24'h000100));
    check("single_done", rv_q[0].done, 1);
    check("single_busy_low", busy, 0);
    repeat (4) @(negedge clk);
    check("rdata_holds", rdata, word_of(24'h000100));

    // Wrapping 4-word burst from requester 1, master holding available over the ack edge.
    hold_mode = 1'b1;
    run_reqs(0, 1, 24'h0, 8'd0, 24'hFFFFF8, 8'd3);
    @(negedge clk);
    req0_addr = 24'hABCDEC; req0_len = 8'd0; req0_valid = 1'b1;
    #1;
    check("ready0_mid_burst", req0_ready, 0);
    check("busy_mid_burst", busy, 1);
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rv(5);
    hold_mode = 1'b0;
    check("wrap_strobes", addr_en_cnt, 5);
    check("ack_per_strobe", ack_cnt, addr_en_cnt);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_addr%0d", i), addr_q[1+i], exp_wrap[i]);
      check($sformatf("wrap_who%0d", i), rv_q[1+i].who, 1);
      check($sformatf("wrap_data%0d", i), rv_q[1+i].data, word_of(exp_wrap[i]));
      check($sformatf("wrap_done%0d", i), rv_q[1+i].done, (i == 3) ? 1 : 0);
    end

    // Contending requesters; inited drops mid-burst and must not disturb it.
    run_reqs(1, 1, 24'h001000, 8'd1, 24'h002000, 8'd1);
    wait_rv(9);
    run_reqs(1, 1, 24'h003000, 8'd1, 24'h004000, 8'd1);
    m_inited = 1'b0;
    wait_rv(13);
    m_inited = 1'b1;
    run_reqs(1, 0, 24'h005000, 8'd0, 24'h0, 8'd0);
    wait_rv(14);
    run_reqs(1, 1, 24'h006000, 8'd1, 24'h007000, 8'd1);
    wait_rv(18);
    for (int i = 0; i < 9; i++) check($sformatf("grant%0d", i), grant_q[i], exp_grant[i]);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("rr_addr%0d", i), addr_q[5+i], exp_addr[i]);
      check($sformatf("rr_who%0d", i), rv_q[5+i].who, exp_who[i]);
      check($sformatf("rr_data%0d", i), rv_q[5+i].data, word_of(exp_addr[i]));
      check($sformatf("rr_done%0d", i), rv_q[5+i].done, exp_done[i]);
    end

    // Reset while waiting for data; reset is held long so the stale word lands inside DRAIN.
    rd_lat = 300;
    aen_before = addr_en_cnt;
    run_reqs(1, 0, 24'h008000, 8'd0, 24'h0, 8'd0);
    budget = 0;
    while (addr_en_cnt == aen_before && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("abort_strobe_seen", addr_en_cnt, aen_before + 1);
    @(negedge clk);
    reset = 1'b1;
    rv_before = rv_q.size();
    drain_before = drain_ack_cnt;
    ack_before = ack_cnt;
    repeat (290) @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_m_addr_data", m_addr_data, 0);
    check("abort_rdata", rdata, 0);
    reset = 1'b0;
    rd_lat = 3;
    run_reqs(1, 0, 24'h009000, 8'd0, 24'h0, 8'd0);
    wait_rv(rv_before + 1);
    repeat (4) @(negedge clk);
    check("drain_acks", drain_ack_cnt - drain_before, 1);
    check("abort_acks_total", ack_cnt - ack_before, 2);
    check("abort_no_extra_rv", rv_q.size(), rv_before + 1);
    check("post_drain_data", rv_q[rv_before].data, word_of(24'h009000));
    check("post_drain_addr", addr_q[addr_q.size()-1], 24'h009000);
    check("drain_gap", last_addr_en_cyc - last_drain_ack_cyc, DRAIN + 3);

    check("addr_en_vs_avail", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
